udp_tx_rr_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that shares the single UDP transmit channel of the UDP/IP core among NUM_PORTS port handlers (DHCP, control, stream, spare). It accepts level requests from the handlers and drives the core's `udp_tx_start`. It tracks the core's 2-bit `udp_tx_result`, returns per-port status, and publishes the grant index that steers the header/data mux. A per-transaction watchdog guarantees that a hung core or a stuck requester cannot lock the channel.

---
 rtl/udp_tx_rr_arbiter.sv | 177 +++++++++++++++++
 tb/tb_udp_tx_rr_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_rr_arbiter.sv
// Round-robin sharing of the single UDP transmit channel among NUM_PORTS handlers,
// with per-transaction watchdog, per-port status and grant index for the tx mux.
module udp_tx_rr_arbiter #(
  parameter int          NUM_PORTS      = 4,
  parameter int          IDX_BITS       = 2,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_PORTS-1:0]   req,
  output logic [NUM_PORTS-1:0]   gnt,
  output logic [IDX_BITS-1:0]    grant_idx,
  output logic [2*NUM_PORTS-1:0] status,
  output logic                   core_start,
  input  logic [1:0]             core_result,
  output logic [15:0]            txn_count,
  output logic [7:0]             timeout_count
);

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  localparam logic [1:0] RES_SENDING = 2'b01;
  localparam logic [1:0] RES_ERR     = 2'b10;

  state_t                 state, state_n;
  logic [IDX_BITS-1:0]    last, last_n, idx_n;
  logic [NUM_PORTS-1:0]   gnt_n, mask, mask_set;
  logic                   start_n;
  logic [1:0]             final_res, res_n;
  logic [23:0]            wd, wd_n;
  logic                   wd_hit;
  logic                   txn_inc, to_inc;
  logic                   req_g;

  logic [NUM_PORTS-1:0]   elig, rot;
  logic [2*NUM_PORTS-1:0] dbl;
  logic                   pick_vld;
  logic [IDX_BITS-1:0]    pick_idx;
  int                     base, off;

  // Rotate the eligible set so the search always starts at last+1, then take the lowest set bit.
  always_comb begin
    elig     = req & ~mask;
    base     = (int'(last) + 1) % NUM_PORTS;
    dbl      = {elig, elig} >> base;
    rot      = dbl[NUM_PORTS-1:0];
    pick_vld = 1'b0;
    off      = 0;
    for (int n = NUM_PORTS - 1; n >= 0; n--) begin
      if (rot[n]) begin
        pick_vld = 1'b1;
        off      = n;
      end
    end
    pick_idx = IDX_BITS'((base + off) % NUM_PORTS);
  end

  assign req_g  = req[grant_idx];
  assign wd_hit = (wd == TIMEOUT_CYCLES - 24'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      gnt           <= '0;
      grant_idx     <= '0;
      last          <= IDX_BITS'(NUM_PORTS - 1);
      core_start    <= 1'b0;
      final_res     <= 2'b00;
      wd            <= '0;
      mask          <= '0;
      txn_count     <= '0;
      timeout_count <= '0;
    end else begin
      state      <= state_n;
      gnt        <= gnt_n;
      grant_idx  <= idx_n;
      last       <= last_n;
      core_start <= start_n;
      final_res  <= res_n;
      wd         <= wd_n;
      // A force-released port becomes eligible again only after it lets go of req once.
      mask       <= (mask & req) | mask_set;
      if (txn_inc) txn_count <= txn_count + 16'd1;
      if (to_inc && timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
    end
  end

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    idx_n    = grant_idx;
    last_n   = last;
    start_n  = core_start;
    res_n    = final_res;
    wd_n     = wd + 24'd1;
    txn_inc  = 1'b0;
    to_inc   = 1'b0;
    mask_set = '0;
    case (state)
      IDLE: begin
        wd_n = '0;
        if (pick_vld) begin
          gnt_n   = NUM_PORTS'(1) << pick_idx;
          idx_n   = pick_idx;
          last_n  = pick_idx;
          start_n = 1'b1;
          state_n = START;
        end
      end
      START: begin
        if (core_result[1]) begin
          res_n   = core_result;
          start_n = 1'b0;
          txn_inc = 1'b1;
          wd_n    = '0;
          state_n = DONE;
        end else if (core_result == RES_SENDING) begin
          wd_n    = '0;
          state_n = BUSY;
        end else if (!req_g) begin
          gnt_n   = '0;
          start_n = 1'b0;
          wd_n    = '0;
          state_n = IDLE;
        end else if (wd_hit) begin
          res_n   = RES_ERR;
          start_n = 1'b0;
          txn_inc = 1'b1;
          to_inc  = 1'b1;
          wd_n    = '0;
          state_n = DONE;
        end
      end
      BUSY: begin
        if (core_result[1]) begin
          res_n   = core_result;
          start_n = 1'b0;
          txn_inc = 1'b1;
          wd_n    = '0;
          state_n = DONE;
        end else if (wd_hit) begin
          res_n   = RES_ERR;
          start_n = 1'b0;
          txn_inc = 1'b1;
          to_inc  = 1'b1;
          wd_n    = '0;
          state_n = DONE;
        end
      end
      DONE: begin
        // gnt stays up here so the mux keeps steering the trailing byte.
        if (!req_g) begin
          gnt_n   = '0;
          wd_n    = '0;
          state_n = IDLE;
        end else if (wd_hit) begin
          mask_set[grant_idx] = 1'b1;
          gnt_n   = '0;
          to_inc  = 1'b1;
          wd_n    = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    logic [1:0] cur;
    cur    = (state == DONE) ? final_res : core_result;
    status = '0;
    for (int n = 0; n < NUM_PORTS; n++) begin
      if (gnt[n] && state != IDLE) status[2*n +: 2] = cur;
    end
  end

endmodule

// File: tb/tb_udp_tx_rr_arbiter.sv
// Scenario bench for udp_tx_rr_arbiter with a transaction-level round-robin reference model.
module tb_udp_tx_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [1:0]  grant_idx;
  logic [7:0]  status;
  logic        core_start;
  logic [1:0]  core_result;
  logic [15:0] txn_count;
  logic [7:0]  timeout_count;

  int checks = 0;
  int errors = 0;

  int         m_last;
  int         m_txn;
  int         m_to;
  logic [3:0] m_mask;

  udp_tx_rr_arbiter #(
    .NUM_PORTS(4), .IDX_BITS(2), .TIMEOUT_CYCLES(24'd16)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .grant_idx(grant_idx),
    .status(status), .core_start(core_start), .core_result(core_result),
    .txn_count(txn_count), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Next winner: first eligible port searching upward from last+1.
  function automatic int rr_pick(int last, logic [3:0] elig);
    for (int k = 1; k <= 4; k++) begin
      int p;
      p = (last + k) % 4;
      if (((elig >> p) & 4'd1) != 4'd0) return p;
    end
    return -1;
  endfunction

  function automatic logic [3:0] onehot(int p);
    return 4'(1 << p);
  endfunction

  function automatic logic [1:0] slot(logic [7:0] st, int p);
    return 2'(st >> (2 * p));
  endfunction

  task automatic model_reset();
    m_last = 3; m_txn = 0; m_to = 0; m_mask = 4'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; core_result = 2'b00;
    tick(); tick();
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", grant_idx); end
    checks++; if (status !== 8'h00) begin errors++; $display("FAIL reset_status got %h want 00", status); end
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", core_start); end
    checks++; if (txn_count !== 16'd0 || timeout_count !== 8'd0) begin
      errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", txn_count, timeout_count);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    int g;
    req = 4'b0001;
    g = rr_pick(m_last, req & ~m_mask);
    tick();
    checks++; if (gnt !== onehot(g) || grant_idx !== 2'(g) || core_start !== 1'b1) begin
      errors++; $display("FAIL single_grant got gnt=%b idx=%0d start=%b want gnt=%b idx=%0d start=1", gnt, grant_idx, core_start, onehot(g), g);
    end
    m_last = g;
    core_result = 2'b01;
    repeat (10) tick();
    checks++; if (slot(status, g) !== 2'b01 || core_start !== 1'b1) begin
      errors++; $display("FAIL single_busy got st=%b start=%b want st=01 start=1", slot(status, g), core_start);
    end
    core_result = 2'b11; #1;
    checks++; if (slot(status, g) !== 2'b11) begin errors++; $display("FAIL single_sent_comb got %b want 11", slot(status, g)); end
    tick();
    core_result = 2'b00; #1;
    checks++; if (slot(status, g) !== 2'b11 || core_start !== 1'b0 || gnt !== onehot(g)) begin
      errors++; $display("FAIL single_done got st=%b start=%b gnt=%b want st=11 start=0 gnt=%b", slot(status, g), core_start, gnt, onehot(g));
    end
    m_txn++;
    req = 4'b0000;
    tick();
    checks++; if (gnt !== 4'b0 || txn_count !== 16'(m_txn)) begin
      errors++; $display("FAIL single_release got gnt=%b txn=%0d want gnt=0000 txn=%0d", gnt, txn_count, m_txn);
    end
  endtask

  task automatic test_fairness();
    req = 4'hF;
    for (int t = 0; t < 16; t++) begin
      int g, n;
      logic [1:0] res;
      g = rr_pick(m_last, req & ~m_mask);
      tick();
      checks++; if (gnt !== onehot(g) || grant_idx !== 2'(g) || core_start !== 1'b1) begin
        errors++; $display("FAIL fair_grant[%0d] got gnt=%b idx=%0d start=%b want gnt=%b idx=%0d", t, gnt, grant_idx, core_start, onehot(g), g);
      end
      m_last = g;
      n   = $urandom_range(1, 8);
      res = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
      core_result = 2'b01;
      repeat (n) tick();
      core_result = res; #1;
      checks++; if (status !== 8'(res) << (2 * g)) begin
        errors++; $display("FAIL fair_status[%0d] got %h want %h", t, status, 8'(res) << (2 * g));
      end
      tick();
      core_result = 2'b00;
      m_txn++;
      checks++; if (core_start !== 1'b0 || gnt !== onehot(g) || txn_count !== 16'(m_txn)) begin
        errors++; $display("FAIL fair_done[%0d] got start=%b gnt=%b txn=%0d want start=0 gnt=%b txn=%0d", t, core_start, gnt, txn_count, onehot(g), m_txn);
      end
      req[g] = 1'b0;
      m_mask = m_mask & req;
      tick();
      checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL fair_gap[%0d] got %b want 0000", t, gnt); end
      req = (t < 5) ? 4'hF : 4'($urandom_range(1, 15));
    end
    req = 4'b0;
    tick();
    tick();
  endtask

  task automatic test_abort();
    int g;
    req = 4'b0100;
    g = rr_pick(m_last, req & ~m_mask);
    tick();
    checks++; if (gnt !== onehot(g) || core_start !== 1'b1) begin
      errors++; $display("FAIL abort_grant got gnt=%b start=%b want gnt=%b start=1", gnt, core_start, onehot(g));
    end
    m_last = g;
    core_result = 2'b00;
    req = 4'b0000;
    tick();
    checks++; if (gnt !== 4'b0 || core_start !== 1'b0 || txn_count !== 16'(m_txn)) begin
      errors++; $display("FAIL abort_drop got gnt=%b start=%b txn=%0d want gnt=0000 start=0 txn=%0d", gnt, core_start, txn_count, m_txn);
    end
    tick();
    checks++; if (gnt !== 4'b0 || status !== 8'h00) begin
      errors++; $display("FAIL abort_idle got gnt=%b st=%h want 0000/00", gnt, status);
    end
  endtask

  task automatic test_core_hang();
    int p, g;
    p = ($urandom_range(0, 1) == 1) ? 3 : 0;
    req = onehot(p);
    g = rr_pick(m_last, req & ~m_mask);
    tick();
    checks++; if (gnt !== onehot(g)) begin errors++; $display("FAIL hang_grant got %b want %b", gnt, onehot(g)); end
    m_last = g;
    core_result = 2'b01;
    repeat (16) tick();
    checks++; if (core_start !== 1'b1 || slot(status, g) !== 2'b01) begin
      errors++; $display("FAIL hang_pre got start=%b st=%b want start=1 st=01", core_start, slot(status, g));
    end
    tick();
    m_to++; m_txn++;
    checks++; if (slot(status, g) !== 2'b10 || core_start !== 1'b0) begin
      errors++; $display("FAIL hang_err got st=%b start=%b want st=10 start=0", slot(status, g), core_start);
    end
    checks++; if (timeout_count !== 8'(m_to) || txn_count !== 16'(m_txn)) begin
      errors++; $display("FAIL hang_counts got to=%0d txn=%0d want to=%0d txn=%0d", timeout_count, txn_count, m_to, m_txn);
    end
    core_result = 2'b00;
    req = 4'b0;
    tick();
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL hang_release got %b want 0000", gnt); end
  endtask

  task automatic test_stuck_requester();
    int g, g2;
    req = 4'b0110;
    g = rr_pick(m_last, req & ~m_mask);
    tick();
    checks++; if (gnt !== onehot(g) || g != 1) begin errors++; $display("FAIL stuck_grant got %b want 0010", gnt); end
    m_last = g;
    core_result = 2'b11;
    tick();
    core_result = 2'b00;
    m_txn++;
    repeat (15) tick();
    checks++; if (gnt !== onehot(g)) begin errors++; $display("FAIL stuck_hold got %b want %b", gnt, onehot(g)); end
    tick();
    m_to++;
    m_mask[g] = 1'b1;
    checks++; if (gnt !== 4'b0 || timeout_count !== 8'(m_to) || txn_count !== 16'(m_txn)) begin
      errors++; $display("FAIL stuck_release got gnt=%b to=%0d txn=%0d want gnt=0000 to=%0d txn=%0d", gnt, timeout_count, txn_count, m_to, m_txn);
    end
    g2 = rr_pick(m_last, req & ~m_mask);
    tick();
    checks++; if (gnt !== onehot(g2)) begin errors++; $display("FAIL stuck_next got %b want %b", gnt, onehot(g2)); end
    m_last = g2;
    core_result = 2'b11;
    tick();
    core_result = 2'b00;
    m_txn++;
    req[g2] = 1'b0;
    tick();
    repeat (3) tick();
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL stuck_masked got %b want 0000", gnt); end
    req = 4'b0000;
    m_mask = m_mask & req;
    tick();
    req = onehot(g);
    g = rr_pick(m_last, req & ~m_mask);
    tick();
    checks++; if (gnt !== onehot(g)) begin errors++; $display("FAIL stuck_regrant got %b want %b", gnt, onehot(g)); end
    m_last = g;
    core_result = 2'b11;
    tick();
    core_result = 2'b00;
    m_txn++;
    req = 4'b0;
    tick();
    checks++; if (txn_count !== 16'(m_txn) || gnt !== 4'b0) begin
      errors++; $display("FAIL stuck_end got txn=%0d gnt=%b want txn=%0d gnt=0000", txn_count, gnt, m_txn);
    end
  endtask

  task automatic test_reset_mid_txn();
    int g;
    req = 4'b1000;
    g = rr_pick(m_last, req & ~m_mask);
    tick();
    core_result = 2'b01;
    repeat (3) tick();
    checks++; if (gnt !== onehot(g) || core_start !== 1'b1) begin
      errors++; $display("FAIL rst_busy got gnt=%b start=%b want gnt=%b start=1", gnt, core_start, onehot(g));
    end
    reset = 1'b1;
    tick();
    checks++; if (gnt !== 4'b0 || core_start !== 1'b0 || grant_idx !== 2'd0 || status !== 8'h00) begin
      errors++; $display("FAIL rst_outputs got gnt=%b start=%b idx=%0d st=%h want all zero", gnt, core_start, grant_idx, status);
    end
    checks++; if (txn_count !== 16'd0 || timeout_count !== 8'd0) begin
      errors++; $display("FAIL rst_counts got %0d/%0d want 0/0", txn_count, timeout_count);
    end
    reset = 1'b0;
    core_result = 2'b00;
    model_reset();
    req = 4'b1100;
    g = rr_pick(m_last, req & ~m_mask);
    tick();
    checks++; if (gnt !== onehot(g) || grant_idx !== 2'(g)) begin
      errors++; $display("FAIL rst_first got gnt=%b idx=%0d want gnt=%b idx=%0d", gnt, grant_idx, onehot(g), g);
    end
    m_last = g;
    core_result = 2'b11;
    tick();
    core_result = 2'b00;
    m_txn++;
    req = 4'b0;
    tick();
    checks++; if (gnt !== 4'b0 || txn_count !== 16'(m_txn)) begin
      errors++; $display("FAIL rst_end got gnt=%b txn=%0d want 0000/%0d", gnt, txn_count, m_txn);
    end
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    core_result = 2'b00;
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_abort();
    test_core_hang();
    test_stuck_requester();
    test_reset_mid_txn();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
